// File: rtl/mob_line_scheduler.sv
// mob_line_scheduler: per-scanline MOB slot loader and pixel resolver.
// CPU-mapped id/vert/horz register file; scans 16 entries into a SLOTS-deep table per line.
module mob_line_scheduler #(
  parameter int NUM_MOB = 16,
  parameter int SLOTS   = 4,
  parameter int TOP_ROW = 239
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [7:0]  data_in,
  input  logic        we_l,
  input  logic        line_start,
  input  logic [7:0]  next_row,
  input  logic [7:0]  col,
  output logic        motionSel,
  output logic        motionWide,
  output logic [7:0]  spriteID,
  output logic [2:0]  mob_row,
  output logic [2:0]  mob_col,
  output logic        scan_busy,
  output logic        overflow,
  output logic [2:0]  slot_count
);
  localparam int IW = $clog2(NUM_MOB);
  localparam int SW = $clog2(SLOTS);
  localparam logic [1:0] IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2;
  logic [7:0]    r_id [NUM_MOB];
  logic [7:0]    r_vert [NUM_MOB];
  logic [7:0]    r_horz [NUM_MOB];
  logic [1:0]    r_state;
  logic [IW-1:0] r_idx;
  logic [7:0]    r_chk;
  logic [2:0]    r_cnt, r_slot_cnt;
  logic          r_ovf;
  // slot record: {id[19:12], horz[11:4], row[3:1], wide[0]}
  logic [19:0]   r_stage [SLOTS];
  logic [19:0]   r_act [SLOTS];
  logic          r_sel, r_wide;
  logic [7:0]    r_sid;
  logic [2:0]    r_row, r_mcol;
  logic [8:0]    w_d;
  logic          w_tall, w_hit, w_sel;
  logic [19:0]   w_rec, w_win;
  logic [2:0]    w_mcol;
  assign w_d    = {1'b0, r_vert[r_idx]} - {1'b0, r_chk};
  assign w_tall = r_idx == IW'(12) || r_idx == IW'(13);
  assign w_hit  = !w_d[8] && w_d[7:0] < (w_tall ? 8'd16 : 8'd8);
  assign w_rec  = {r_id[r_idx], r_horz[r_idx], w_d[2:0], w_d[3]};
  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i < NUM_MOB; i++) begin
        r_id[i]   <= '0;
        r_vert[i] <= '0;
        r_horz[i] <= '0;
      end
    end else if (!we_l) begin
      if (addr[15:4] == 12'h07C) r_id[addr[IW-1:0]] <= data_in;
      if (addr[15:4] == 12'h07D) r_vert[addr[IW-1:0]] <= data_in;
      if (addr[15:4] == 12'h07E) r_horz[addr[IW-1:0]] <= data_in;
    end
  always_ff @(posedge clk)
    if (rst) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_chk      <= '0;
      r_cnt      <= '0;
      r_slot_cnt <= '0;
      r_ovf      <= 1'b0;
      for (int s = 0; s < SLOTS; s++) begin
        r_stage[s] <= '0;
        r_act[s]   <= '0;
      end
    end else if (line_start) begin
      r_state <= SCAN;
      r_idx   <= '0;
      r_chk   <= 8'(TOP_ROW) - next_row;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      for (int s = 0; s < SLOTS; s++) r_stage[s] <= '0;
    end else if (r_state == SCAN) begin
      if (w_hit && r_cnt < 3'(SLOTS)) begin
        r_stage[r_cnt[SW-1:0]] <= w_rec;
        r_cnt <= r_cnt + 3'd1;
      end else if (w_hit) r_ovf <= 1'b1;
      r_idx   <= r_idx + 1'b1;
      r_state <= r_idx == IW'(NUM_MOB - 1) ? DONE : SCAN;
    end else if (r_state == DONE) begin
      r_act      <= r_stage;
      r_slot_cnt <= r_cnt;
      r_state    <= IDLE;
    end
  // iterate high to low so the lowest valid slot overrides
  always_comb begin
    w_sel  = 1'b0;
    w_win  = '0;
    w_mcol = '0;
    for (int s = SLOTS - 1; s >= 0; s--)
      if (3'(s) < r_slot_cnt && {1'b0, col} >= {1'b0, r_act[s][11:4]} &&
          {1'b0, col} < {1'b0, r_act[s][11:4]} + 9'd8) begin
        w_sel  = 1'b1;
        w_win  = r_act[s];
        w_mcol = col[2:0] - r_act[s][6:4];
      end
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_sel  <= 1'b0;
      r_wide <= 1'b0;
      r_sid  <= '0;
      r_row  <= '0;
      r_mcol <= '0;
    end else begin
      r_sel  <= w_sel;
      r_wide <= w_win[0];
      r_sid  <= w_win[19:12];
      r_row  <= w_win[3:1];
      r_mcol <= w_mcol;
    end
  assign motionSel  = r_sel;
  assign motionWide = r_wide;
  assign spriteID   = r_sid;
  assign mob_row    = r_row;
  assign mob_col    = r_mcol;
  assign scan_busy  = r_state == SCAN || r_state == DONE;
  assign overflow   = r_ovf;
  assign slot_count = r_slot_cnt;
endmodule

// File: tb/tb_mob_line_scheduler.sv
// tb_mob_line_scheduler: randomized + directed bench with scoreboard queue and a
// behavioural model of the register file, per-line hit list and pixel priority.
module tb_mob_line_scheduler;
  logic clk = 0, rst = 1;
  logic [15:0] addr = 0;
  logic [7:0] data_in = 0, next_row = 0, col = 0;
  logic we_l = 1, line_start = 0;
  logic motionSel, motionWide, scan_busy, overflow;
  logic [7:0] spriteID;
  logic [2:0] mob_row, mob_col, slot_count;
  int n_chk = 0, n_pass = 0;
  logic [7:0] m_id [16], m_vert [16], m_horz [16];
  logic [7:0] a_id [4], a_h [4], p_id [4], p_h [4];
  logic [2:0] a_row [4], p_row [4];
  logic a_w [4], p_w [4];
  int a_n = 0, p_n = 0;
  bit p_ovf = 0;
  logic [15:0] pq[$];
  logic [7:0] cq[$];
  logic [15:0] mon_e;
  logic [7:0] mon_c;

  always #5 clk = ~clk;

  mob_line_scheduler dut (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .we_l(we_l),
    .line_start(line_start), .next_row(next_row), .col(col),
    .motionSel(motionSel), .motionWide(motionWide), .spriteID(spriteID),
    .mob_row(mob_row), .mob_col(mob_col), .scan_busy(scan_busy),
    .overflow(overflow), .slot_count(slot_count)
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic build(input logic [7:0] row);
    int c, d, h;
    c = (239 - int'(row)) & 255;
    p_n = 0;
    p_ovf = 0;
    for (int i = 0; i < 16; i++) begin
      d = int'(m_vert[i]) - c;
      h = (i == 12 || i == 13) ? 16 : 8;
      if (d >= 0 && d < h) begin
        if (p_n < 4) begin
          p_id[p_n] = m_id[i]; p_h[p_n] = m_horz[i];
          p_row[p_n] = 3'(d % 8); p_w[p_n] = d >= 8;
          p_n++;
        end else p_ovf = 1;
      end
    end
  endtask

  function automatic logic [15:0] exp_pix(input logic [7:0] c);
    for (int s = 0; s < a_n; s++)
      if (int'(c) >= int'(a_h[s]) && int'(c) < int'(a_h[s]) + 8)
        return {1'b1, a_w[s], a_id[s], a_row[s], 3'(int'(c) - int'(a_h[s]))};
    return 16'h0;
  endfunction

  task automatic pix(input logic [7:0] c);
    @(negedge clk);
    col = c;
    pq.push_back(exp_pix(c));
    cq.push_back(c);
  endtask

  task automatic wr(input logic [1:0] k, input logic [3:0] i, input logic [7:0] v);
    @(negedge clk);
    addr = {12'h07C + 12'(k), i};
    data_in = v;
    we_l = 0;
    @(negedge clk);
    we_l = 1;
    addr = 16'h0;
    if (k == 0) m_id[i] = v;
    else if (k == 1) m_vert[i] = v;
    else if (k == 2) m_horz[i] = v;
  endtask

  task automatic ls(input logic [7:0] row);
    @(negedge clk);
    next_row = row;
    line_start = 1;
    build(row);
    @(negedge clk);
    line_start = 0;
  endtask

  task automatic wait_done(input int ek);
    int k = 0;
    while (scan_busy && k < 40) begin @(negedge clk); k++; end
    if (ek >= 0) chk("busy cycles", 16'(k), 16'(ek));
    else chk("scan ends", 16'(scan_busy), 16'h0);
    a_id = p_id; a_h = p_h; a_row = p_row; a_w = p_w; a_n = p_n;
    chk("slot_count", 16'(slot_count), 16'(a_n));
    chk("overflow", 16'(overflow), 16'(p_ovf));
  endtask

  always @(posedge clk) begin
    #1;
    if (pq.size() > 0) begin
      mon_e = pq.pop_front();
      mon_c = cq.pop_front();
      chk($sformatf("pix col=%h", mon_c),
          {motionSel, motionWide, spriteID, mob_row, mob_col}, mon_e);
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin m_id[i] = 0; m_vert[i] = 0; m_horz[i] = 0; end
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("reset outputs", {motionSel, motionWide, spriteID, mob_row, mob_col}, 16'h0);
    chk("reset status", {scan_busy, overflow, slot_count}, 16'h0);

    // single object, column edges
    wr(0, 0, 8'h01); wr(1, 0, 8'h0A); wr(2, 0, 8'h0A);
    ls(8'd229); wait_done(17);
    pix(8'd10);
    @(posedge clk); #2;
    chk("t1 direct", {motionSel, spriteID, mob_col, mob_row}, {1'b1, 8'h01, 3'd0, 3'd0});
    pix(8'd17); pix(8'd18); pix(8'd9);

    // d = 8 misses a short object; 16-tall entry 12 shows wide tile
    ls(8'd237); wait_done(17);
    chk("t2 miss count", 16'(slot_count), 16'h0);
    pix(8'd10);
    wr(0, 12, 8'h14); wr(1, 12, 8'h0A); wr(2, 12, 8'h20);
    ls(8'd237); wait_done(17);
    pix(8'h20);
    @(posedge clk); #2;
    chk("t2 direct", {motionSel, motionWide, spriteID, mob_row}, {1'b1, 1'b1, 8'h14, 3'd0});
    pix(8'h27); pix(8'h28);

    // five hits on one line -> overflow, entry 4 dropped
    for (int i = 0; i < 5; i++) begin
      wr(0, 4'(i), 8'(8'h30 + i)); wr(1, 4'(i), 8'h50); wr(2, 4'(i), 8'(8'h10 + 16 * i));
    end
    ls(8'd159); wait_done(17);
    chk("t3 direct", {overflow, slot_count}, {1'b1, 3'd4});
    pix(8'h10); pix(8'h40); pix(8'h50); pix(8'h57);

    // overlap: lowest index wins; ignored address must not write
    wr(1, 0, 8'h00); wr(1, 1, 8'h00); wr(1, 3, 8'h00);
    wr(0, 5, 8'h55); wr(1, 5, 8'h50); wr(2, 5, 8'h40); wr(2, 2, 8'h40);
    wr(3, 2, 8'hFF);
    ls(8'd159); wait_done(17);
    pix(8'h40);
    @(posedge clk); #2;
    chk("t4 direct", 16'(spriteID), 16'h32);
    pix(8'h47); pix(8'h48); pix(8'h50);

    // write colliding with the scanner's read of entry 3
    wr(0, 3, 8'h33); wr(1, 3, 8'h50); wr(2, 3, 8'h80);
    ls(8'd159);
    repeat (2) @(negedge clk);
    wr(2, 3, 8'h90);
    wait_done(13);
    pix(8'h80); pix(8'h90);
    ls(8'd159); wait_done(17);
    pix(8'h80); pix(8'h90);

    // randomized lines
    for (int it = 0; it < 8; it++) begin
      int c, t;
      c = int'($urandom_range(0, 200));
      for (int j = 0; j < 7; j++) begin
        logic [3:0] e;
        e = 4'($urandom_range(0, 15));
        t = int'($urandom_range(0, 20)) - 3;
        wr(0, e, 8'($urandom));
        wr(1, e, 8'(c + t));
        wr(2, e, 8'($urandom));
      end
      @(negedge clk);
      addr = 16'h1000 | 16'($urandom_range(0, 16'hEFFF)); data_in = 8'($urandom); we_l = 0;
      @(negedge clk); we_l = 1; addr = 0;
      ls(8'(239 - c)); wait_done(17);
      for (int j = 0; j < 24; j++) pix(j < 8 ? 8'(a_h[0] + j) : 8'($urandom));
    end

    // restart mid-scan: old table held until the new DONE
    ls(8'd159);
    repeat (6) @(negedge clk);
    ls(8'd229);
    for (int j = 0; j < 5; j++) pix(8'(a_h[j % 4] + 3));
    wait_done(12);
    for (int j = 0; j < 4; j++) pix(8'(a_h[j] + 1));

    // reset mid-scan discards everything
    ls(8'd159);
    repeat (4) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 16; i++) begin m_id[i] = 0; m_vert[i] = 0; m_horz[i] = 0; end
    a_n = 0;
    chk("rst mid outputs", {motionSel, motionWide, spriteID, mob_row, mob_col}, 16'h0);
    chk("rst mid status", {scan_busy, overflow, slot_count}, 16'h0);
    pix(8'h00);

    // reset entries (vert 0) hit checkRow 0 only
    ls(8'd239); wait_done(17);
    pix(8'h00); pix(8'h07); pix(8'h08);
    ls(8'd238); wait_done(17);
    pix(8'h00);
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mob_line_scheduler.md
Name: mob_line_scheduler

Overview:
- Per-scanline scheduler for the 16 motion objects (MOBs).
- Owns the MOB ID/vertical/horizontal register file as CPU memory-mapped I/O.
- At each line_start it walks the 16 entries one per cycle and loads up to SLOTS hitting objects into a per-line slot table.
- During active video it resolves col against that table only, replacing 16 parallel compares with a sequential scan. Outputs feed pixelLookup.

Parameters:
NUM_MOB, 16, number of motion object entries (index 0..15)
SLOTS, 4, maximum objects displayed on one scanline
TOP_ROW, 239, checkRow = TOP_ROW - next_row

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
addr  in  16  6502 address bus
data_in  in  8  6502 write data
we_l  in  1  active-low write strobe
line_start  in  1  one-cycle pulse in hblank; begins the scan for next_row
next_row  in  8  row about to be displayed; sampled when line_start=1
col  in  8  current pixel column during active video
motionSel  out  1  MOB pixel hit, registered
motionWide  out  1  hit is in the second 8-row tile of a 16-tall object
spriteID  out  8  ID of the winning object
mob_row  out  3  row within tile
mob_col  out  3  column within tile
scan_busy  out  1  scan in progress
overflow  out  1  more than SLOTS objects hit the current scanned line
slot_count  out  3  number of valid slots in the active table (0..SLOTS)

Behaviour:
- Register file: id/vert/horz[16] x 8 bits.
  - Writes occur when we_l=0 and addr[15:4] is 0x07C (ID), 0x07D (vert) or 0x07E (horz); index is addr[3:0].
  - Writes take effect next edge. Other addresses are ignored.
  - CPU writes always win and never stall. When the scanner reads entry i in the same cycle that entry i is written, the scanner uses the pre-write value.
- Height: 16 for entries 12 and 13, otherwise 8.
- Hit test for entry i: d = vert[i] - checkRow, 9-bit signed. Hit iff 0 <= d < height.
  - Slot record = {id, horz, row = d[2:0], wide = d[3]}.
- FSM IDLE -> SCAN -> DONE -> IDLE.
  - line_start in any state: latch checkRow, idx = 0, clear staging table and count, clear overflow, go to SCAN. This aborts any scan in progress.
  - SCAN: test entry idx each cycle, in ascending index order.
    - Hit with count < SLOTS: write the record to staging[count] and increment count.
    - Hit with count == SLOTS: set overflow and drop the entry.
    - After idx = NUM_MOB-1, go to DONE.
  - DONE (1 cycle): copy staging to the active table, set slot_count = count, go to IDLE.
  - scan_busy = 1 in SCAN and DONE.
  - New table is visible from cycle line_start+18. hblank must be at least 18 cycles.
- Active table is never modified outside DONE. Output compares during a scan use the previous line's table.
- Pixel resolve:
  - Hit on valid slot s iff horz <= col < horz+8, evaluated as a 9-bit comparison. There is no wrap: horz 0xF8 covers columns 0xF8..0xFF only.
  - The lowest slot wins, which is the lowest MOB index.
  - Outputs are registered: 1-cycle latency from col.
  - mob_col = (col - horz)[2:0], mob_row = slot row, motionWide = slot wide.
  - On a miss, all outputs are 0.
- Reset: all registers, both tables, slot_count, overflow, scan_busy and all pixel outputs go to 0; FSM goes to IDLE. Reset mid-scan discards the scan.
- Entries reset with vert = 0. Such an entry hits only checkRow 0 (next_row 239), with d = 0.

Test Plan:
1. Write ID[0]=0x01, vert[0]=0x0A, horz[0]=0x0A. Pulse line_start with next_row=229 (checkRow 10). Drive col=10, 17, 18 after cycle 18 -> motionSel 1/1/0; mob_col 0/7; mob_row 0; spriteID 0x01; slot_count 1.
2. Same setup, next_row=237 (checkRow 2, d=8) -> entry 0 is a miss, slot_count 0. Then ID[12]=0x14, vert[12]=0x0A, horz[12]=0x20, next_row=237 -> col 0x20 gives motionWide=1, mob_row=0, spriteID=0x14.
3. Five entries 0..4 with vert=0x50, horz=0x10 + 16i, line_start for checkRow 0x50 -> slot_count 4, overflow 1, entry 4 absent, entry 0 present at col 0x10.
4. Overlap: entries 2 and 5 both at horz 0x40 on the same line -> spriteID = ID[2].
5. CPU writes horz[3] at the cycle the scanner reads entry 3 -> this line uses the old horz. After the next line_start, the new value is used.
6. line_start again at scan cycle 8 -> scan restarts; old table is held until the new DONE. rst at scan cycle 5 -> all outputs 0, scan_busy 0, slot_count 0.
